// File: rtl/aemb2_xsl_pkg.sv
// Shared definitions for the XSL slave: entry field widths and FSM state encoding.
package aemb2_xsl_pkg;
  localparam int XSL_DAT_W = 32;
  localparam int XSL_CTL_W = 1;
  localparam int XSL_RX_W  = XSL_DAT_W + XSL_CTL_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } xsl_state_e;

  function automatic int xsl_chn_w(input int xwb_w);
    return xwb_w - 2;
  endfunction
endpackage

// File: rtl/aemb2_xsl_fifo.sv
// Synchronous FIFO, 2**AW entries, first-word fall-through head on dat_o.
module aemb2_xsl_fifo #(
  parameter int DATA_W = 33,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic              push_ok, pop_ok;

  // Full/empty come from the registered pointers, so a push and pop in the
  // same cycle are each judged against the pre-update occupancy.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dat_o   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + PTR_ONE;
    if (pop_ok)  rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= dat_i;
  end
endmodule

// File: rtl/aemb2_xsl_slave.sv
// XSL bus responder: core puts land in a TX FIFO toward the accelerator,
// core gets are served from an RX FIFO the accelerator fills; ack blocks until possible.
module aemb2_xsl_slave
  import aemb2_xsl_pkg::*;
#(
  parameter int AEMB_XWB = 5,
  parameter int AEMB_XAW = 3
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [AEMB_XWB-3:0] xwb_adr_i,
  input  logic [31:0]         xwb_dat_i,
  input  logic [3:0]          xwb_sel_i,
  input  logic                xwb_stb_i,
  input  logic                xwb_cyc_i,
  input  logic                xwb_wre_i,
  input  logic                xwb_tag_i,
  output logic [31:0]         xwb_dat_o,
  output logic                xwb_ack_o,
  output logic [31:0]         txs_dat_o,
  output logic [AEMB_XWB-3:0] txs_chn_o,
  output logic                txs_ctl_o,
  output logic                txs_vld_o,
  input  logic                txs_rdy_i,
  input  logic [31:0]         rxs_dat_i,
  input  logic                rxs_ctl_i,
  input  logic                rxs_vld_i,
  output logic                rxs_rdy_o,
  output logic                ctl_err_o
);
  localparam int CHN_W = xsl_chn_w(AEMB_XWB);
  localparam int TX_W  = XSL_DAT_W + XSL_CTL_W + CHN_W;

  xsl_state_e           state_q, state_d;
  logic [XSL_DAT_W-1:0] dat_q, dat_d;
  logic                 err_q, err_d;
  logic                 req;
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [TX_W-1:0]      tx_head;
  logic [XSL_RX_W-1:0]  rx_head;
  logic                 unused_sel;

  // Every transfer is a full word; byte selects carry no information here.
  assign unused_sel = ^xwb_sel_i;

  assign req = xwb_stb_i & xwb_cyc_i;

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    err_d   = err_q;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && xwb_wre_i && !tx_full) begin
          tx_push = 1'b1;
          state_d = ST_ACK;
        end else if (req && !xwb_wre_i && !rx_empty) begin
          rx_pop  = 1'b1;
          dat_d   = rx_head[XSL_DAT_W-1:0];
          if (rx_head[XSL_DAT_W] != xwb_tag_i) err_d = 1'b1;
          state_d = ST_ACK;
        end
      end
      // Request is ignored while acking so a held strobe is not taken twice.
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      dat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
    end
  end

  assign xwb_ack_o = (state_q == ST_ACK);
  assign xwb_dat_o = dat_q;
  assign ctl_err_o = err_q;

  assign txs_vld_o = !tx_empty;
  assign tx_pop    = txs_vld_o & txs_rdy_i;
  assign txs_dat_o = tx_head[XSL_DAT_W-1:0];
  assign txs_chn_o = tx_head[XSL_DAT_W +: CHN_W];
  assign txs_ctl_o = tx_head[TX_W-1];

  assign rxs_rdy_o = !rx_full;
  assign rx_push   = rxs_vld_i & rxs_rdy_o;

  aemb2_xsl_fifo #(.DATA_W(TX_W), .AW(AEMB_XAW)) u_tx_fifo (
    .clk     (sys_clk_i),
    .rst     (sys_rst_i),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .dat_i   ({xwb_tag_i, xwb_adr_i, xwb_dat_i}),
    .dat_o   (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  aemb2_xsl_fifo #(.DATA_W(XSL_RX_W), .AW(AEMB_XAW)) u_rx_fifo (
    .clk     (sys_clk_i),
    .rst     (sys_rst_i),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .dat_i   ({rxs_ctl_i, rxs_dat_i}),
    .dat_o   (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );
endmodule

// File: tb/tb_aemb2_xsl_slave.sv
// Directed bench for aemb2_xsl_slave: put/get handshakes, blocking, FIFO full/wrap, ctl error, reset.
module tb_aemb2_xsl_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  xwb_adr;
  logic [31:0] xwb_dat_i;
  logic [3:0]  xwb_sel;
  logic        xwb_stb, xwb_cyc, xwb_wre, xwb_tag;
  logic [31:0] xwb_dat_o;
  logic        xwb_ack;
  logic [31:0] txs_dat;
  logic [2:0]  txs_chn;
  logic        txs_ctl, txs_vld, txs_rdy;
  logic [31:0] rxs_dat;
  logic        rxs_ctl, rxs_vld, rxs_rdy;
  logic        ctl_err;

  int checks = 0;
  int errors = 0;

  aemb2_xsl_slave #(.AEMB_XWB(5), .AEMB_XAW(3)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .xwb_adr_i (xwb_adr),
    .xwb_dat_i (xwb_dat_i),
    .xwb_sel_i (xwb_sel),
    .xwb_stb_i (xwb_stb),
    .xwb_cyc_i (xwb_cyc),
    .xwb_wre_i (xwb_wre),
    .xwb_tag_i (xwb_tag),
    .xwb_dat_o (xwb_dat_o),
    .xwb_ack_o (xwb_ack),
    .txs_dat_o (txs_dat),
    .txs_chn_o (txs_chn),
    .txs_ctl_o (txs_ctl),
    .txs_vld_o (txs_vld),
    .txs_rdy_i (txs_rdy),
    .rxs_dat_i (rxs_dat),
    .rxs_ctl_i (rxs_ctl),
    .rxs_vld_i (rxs_vld),
    .rxs_rdy_o (rxs_rdy),
    .ctl_err_o (ctl_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a cycle and wait up to max_cyc edges for ack; strobe is dropped on return.
  task automatic xact_start(input logic wre, input logic [2:0] adr, input logic [31:0] dat,
                            input logic tag, input int max_cyc, output logic acked);
    xwb_adr = adr; xwb_dat_i = dat; xwb_tag = tag; xwb_wre = wre;
    xwb_stb = 1'b1; xwb_cyc = 1'b1;
    acked = 1'b0;
    for (int n = 0; n < max_cyc && !acked; n++) begin
      tick();
      if (xwb_ack) acked = 1'b1;
    end
    xwb_stb = 1'b0; xwb_cyc = 1'b0;
  endtask

  // Unblocked transaction: ack must arrive after one edge and last one cycle.
  task automatic xact(input string tag_s, input logic wre, input logic [2:0] adr,
                      input logic [31:0] dat, input logic tag);
    logic acked;
    xact_start(wre, adr, dat, tag, 1, acked);
    check({tag_s, "_ack"}, acked, 1'b1);
    tick();
    check({tag_s, "_ack_drop"}, xwb_ack, 1'b0);
  endtask

  task automatic rx_push(input logic [31:0] dat, input logic ctl);
    rxs_dat = dat; rxs_ctl = ctl; rxs_vld = 1'b1;
    tick();
    rxs_vld = 1'b0;
  endtask

  initial begin
    logic acked;
    int   acks;
    logic [2:0] a3;
    logic [31:0] d32;

    rst = 1'b1; xwb_adr = '0; xwb_dat_i = '0; xwb_sel = 4'hF; xwb_stb = 0; xwb_cyc = 0;
    xwb_wre = 0; xwb_tag = 0; txs_rdy = 0; rxs_dat = '0; rxs_ctl = 0; rxs_vld = 0;
    tick(); tick();
    check("rst_ack", xwb_ack, 1'b0);
    check("rst_dat", xwb_dat_o, 32'h0);
    check("rst_err", ctl_err, 1'b0);
    check("rst_txvld", txs_vld, 1'b0);
    check("rst_rxrdy", rxs_rdy, 1'b1);
    rst = 1'b0;
    tick();

    // Put to empty TX
    xact_start(1'b1, 3'd2, 32'hDEADBEEF, 1'b1, 1, acked);
    check("put1_ack", acked, 1'b1);
    check("put1_txdat", txs_dat, 32'hDEADBEEF);
    check("put1_txchn", txs_chn, 3'd2);
    check("put1_txctl", txs_ctl, 1'b1);
    check("put1_txvld", txs_vld, 1'b1);
    tick();
    check("put1_ack_drop", xwb_ack, 1'b0);
    check("put1_dat_hold", xwb_dat_o, 32'h0);
    txs_rdy = 1'b1; tick(); txs_rdy = 1'b0;
    check("put1_drained", txs_vld, 1'b0);

    // Get blocks on empty RX, then completes two edges after the stream push is offered
    xwb_wre = 1'b0; xwb_tag = 1'b0; xwb_stb = 1'b1; xwb_cyc = 1'b1;
    acks = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (xwb_ack) acks++;
    end
    check("get_block", acks, 0);
    rxs_dat = 32'h12345678; rxs_ctl = 1'b0; rxs_vld = 1'b1;
    tick();
    rxs_vld = 1'b0;
    check("get_wait1", xwb_ack, 1'b0);
    tick();
    check("get_ack", xwb_ack, 1'b1);
    check("get_dat", xwb_dat_o, 32'h12345678);
    check("get_err", ctl_err, 1'b0);
    xwb_stb = 1'b0; xwb_cyc = 1'b0;
    tick();
    check("get_ack_drop", xwb_ack, 1'b0);

    // TX full: eight puts accepted, ninth stalls until one entry drains
    for (int i = 0; i < 8; i++) begin
      a3 = i[2:0]; d32 = i;
      xact("txfill", 1'b1, a3, d32, i[0]);
    end
    xwb_adr = 3'd0; xwb_dat_i = 32'd8; xwb_tag = 1'b0; xwb_wre = 1'b1;
    xwb_stb = 1'b1; xwb_cyc = 1'b1;
    acks = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (xwb_ack) acks++;
    end
    check("txfull_stall", acks, 0);
    check("txfull_head", txs_dat, 32'd0);
    txs_rdy = 1'b1;
    tick();
    txs_rdy = 1'b0;
    check("txfull_push_refused", xwb_ack, 1'b0);
    tick();
    check("txfull_ninth_ack", xwb_ack, 1'b1);
    xwb_stb = 1'b0; xwb_cyc = 1'b0;
    tick();
    txs_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("txdrain_dat", txs_dat, i);
      check("txdrain_chn", txs_chn, i % 8);
      tick();
    end
    txs_rdy = 1'b0;
    check("txdrain_empty", txs_vld, 1'b0);

    // RX full: eight stream pushes fill it, a ninth is refused
    for (int i = 0; i < 8; i++) rx_push(200 + i, 1'b0);
    check("rxfull_rdy", rxs_rdy, 1'b0);
    rx_push(32'd208, 1'b0);
    check("rxfull_rdy_hold", rxs_rdy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      xact("rxdrain", 1'b0, 3'd0, 32'd0, 1'b0);
      check("rxdrain_dat", xwb_dat_o, 200 + i);
    end
    check("rxdrain_rdy", rxs_rdy, 1'b1);
    xact_start(1'b0, 3'd0, 32'd0, 1'b0, 3, acked);
    check("rx_ninth_dropped", acked, 1'b0);

    // RX pointer wrap with interleaved push/get
    for (int k = 0; k < 20; k++) begin
      rx_push(100 + k, 1'b0);
      check("wrap_rdy", rxs_rdy, 1'b1);
      xact("wrap_get", 1'b0, 3'd0, 32'd0, 1'b0);
      check("wrap_dat", xwb_dat_o, 100 + k);
    end
    check("wrap_err", ctl_err, 1'b0);

    // Control mismatch sets the sticky error
    rx_push(32'hA5A5A5A5, 1'b1);
    xact("mis_get", 1'b0, 3'd0, 32'd0, 1'b0);
    check("mis_dat", xwb_dat_o, 32'hA5A5A5A5);
    check("mis_err", ctl_err, 1'b1);
    xact("mis_put", 1'b1, 3'd1, 32'h11, 1'b0);
    tick(); tick();
    check("mis_err_sticky", ctl_err, 1'b1);
    check("mis_dat_hold", xwb_dat_o, 32'hA5A5A5A5);

    // Reset while acking with three TX entries held
    xact("rst_put2", 1'b1, 3'd2, 32'h22, 1'b0);
    xact_start(1'b1, 3'd3, 32'h33, 1'b0, 1, acked);
    check("rstmid_ack", acked, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_ack_clr", xwb_ack, 1'b0);
    check("rstmid_txvld", txs_vld, 1'b0);
    check("rstmid_rxrdy", rxs_rdy, 1'b1);
    check("rstmid_err", ctl_err, 1'b0);
    check("rstmid_dat", xwb_dat_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
